// File: rtl/controlador_display_mux_if.sv
// Bus bundle for the 7-segment scan controller.
// master: drives enable, packed BCD digits, dot requests and the blanking mode, and receives the display pins.
// slave: the controller side, which receives those inputs and drives bcd_out, anodo_n, dp_n and fim_quadro.
interface controlador_display_mux_if #(
  parameter int N_DIGITOS = 4
);
  logic                     enable;
  logic [4*N_DIGITOS-1:0]   digitos_in;
  logic [N_DIGITOS-1:0]     pontos_in;
  logic                     apaga_zeros;
  logic [3:0]               bcd_out;
  logic [N_DIGITOS-1:0]     anodo_n;
  logic                     dp_n;
  logic                     fim_quadro;

  modport master (
    output enable, digitos_in, pontos_in, apaga_zeros,
    input  bcd_out, anodo_n, dp_n, fim_quadro
  );

  modport slave (
    input  enable, digitos_in, pontos_in, apaga_zeros,
    output bcd_out, anodo_n, dp_n, fim_quadro
  );
endinterface

// File: rtl/controlador_display_mux.sv
// Time-multiplexed scan controller for an N-digit common-anode 7-segment display.
// Each slot starts with a blanked guard time, then lights one anode. All outputs are registered.
// Ports: clk and reset (synchronous, active-high), plus the controlador_display_mux_if slave bundle.
// The bundle carries enable, the digits, the dots, apaga_zeros, bcd_out, anodo_n, dp_n and fim_quadro.
// The digit, dot and blanking inputs are snapshotted once per frame, so changes only appear at frame boundaries.
module controlador_display_mux #(
  parameter int N_DIGITOS   = 4,
  parameter int DIV_REFRESH = 50000,
  parameter int GUARDA      = 500
) (
  input  logic                      clk,
  input  logic                      reset,
  controlador_display_mux_if.slave  bus
);

  localparam int IW = (N_DIGITOS > 1) ? $clog2(N_DIGITOS) : 1;
  localparam int CW = (DIV_REFRESH > 1) ? $clog2(DIV_REFRESH) : 1;

  localparam logic [CW-1:0] CNT_GUARDA_FIM = CW'(GUARDA - 1);
  localparam logic [CW-1:0] CNT_SLOT_FIM   = CW'(DIV_REFRESH - 1);
  localparam logic [IW-1:0] IDX_ULTIMO     = IW'(N_DIGITOS - 1);

  typedef enum logic [1:0] {
    EST_OCIOSO = 2'd0,
    EST_GUARDA = 2'd1,
    EST_ATIVO  = 2'd2
  } estado_t;

  estado_t                 estado, estado_nxt;
  logic [CW-1:0]           cnt, cnt_nxt;
  logic [IW-1:0]           idx, idx_nxt;
  logic [4*N_DIGITOS-1:0]  snap_dig, snap_dig_nxt;
  logic [N_DIGITOS-1:0]    snap_pts, snap_pts_nxt;
  logic                    snap_apz, snap_apz_nxt;

  logic [3:0]              bcd_nxt;
  logic [N_DIGITOS-1:0]    anodo_nxt;
  logic                    dp_nxt;
  logic                    fim_nxt;
  logic                    apagado;

  // A digit is blanked when it is not the rightmost one and it and every digit to its left are zero.
  function automatic logic zero_a_esquerda(
    input logic [IW-1:0]          pos,
    input logic [4*N_DIGITOS-1:0] dig,
    input logic                   apz
  );
    logic todos_zero;
    todos_zero = 1'b1;
    for (int i = 0; i < N_DIGITOS; i++) begin
      if ((i >= int'(pos)) && (dig[4*i +: 4] != 4'd0)) todos_zero = 1'b0;
    end
    return apz && (pos != '0) && todos_zero;
  endfunction

  always_ff @(posedge clk) begin
    if (reset) begin
      estado         <= EST_OCIOSO;
      cnt            <= '0;
      idx            <= '0;
      snap_dig       <= '0;
      snap_pts       <= '0;
      snap_apz       <= 1'b0;
      bus.bcd_out    <= 4'hF;
      bus.anodo_n    <= '1;
      bus.dp_n       <= 1'b1;
      bus.fim_quadro <= 1'b0;
    end else begin
      estado         <= estado_nxt;
      cnt            <= cnt_nxt;
      idx            <= idx_nxt;
      snap_dig       <= snap_dig_nxt;
      snap_pts       <= snap_pts_nxt;
      snap_apz       <= snap_apz_nxt;
      bus.bcd_out    <= bcd_nxt;
      bus.anodo_n    <= anodo_nxt;
      bus.dp_n       <= dp_nxt;
      bus.fim_quadro <= fim_nxt;
    end
  end

  always_comb begin
    estado_nxt   = estado;
    cnt_nxt      = cnt;
    idx_nxt      = idx;
    snap_dig_nxt = snap_dig;
    snap_pts_nxt = snap_pts;
    snap_apz_nxt = snap_apz;
    fim_nxt      = 1'b0;
    bcd_nxt      = 4'hF;
    anodo_nxt    = '1;
    dp_nxt       = 1'b1;
    apagado      = 1'b0;

    if (!bus.enable) begin
      // Dropping enable abandons the frame at once; no end-of-frame pulse is produced.
      estado_nxt = EST_OCIOSO;
      cnt_nxt    = '0;
      idx_nxt    = '0;
    end else begin
      unique case (estado)
        EST_OCIOSO: begin
          estado_nxt   = EST_GUARDA;
          cnt_nxt      = '0;
          idx_nxt      = '0;
          snap_dig_nxt = bus.digitos_in;
          snap_pts_nxt = bus.pontos_in;
          snap_apz_nxt = bus.apaga_zeros;
        end
        EST_GUARDA: begin
          if (cnt == CNT_GUARDA_FIM) estado_nxt = EST_ATIVO;
          cnt_nxt = cnt + 1'b1;
        end
        EST_ATIVO: begin
          if (cnt == CNT_SLOT_FIM) begin
            cnt_nxt    = '0;
            estado_nxt = EST_GUARDA;
            if (idx == IDX_ULTIMO) begin
              idx_nxt      = '0;
              snap_dig_nxt = bus.digitos_in;
              snap_pts_nxt = bus.pontos_in;
              snap_apz_nxt = bus.apaga_zeros;
              fim_nxt      = 1'b1;
            end else begin
              idx_nxt = idx + 1'b1;
            end
          end else begin
            cnt_nxt = cnt + 1'b1;
          end
        end
        default: begin
          estado_nxt = EST_OCIOSO;
          cnt_nxt    = '0;
          idx_nxt    = '0;
        end
      endcase
    end

    // Outputs are derived from the next state, so the output registers line up with the state registers.
    if (estado_nxt != EST_OCIOSO) begin
      apagado = zero_a_esquerda(idx_nxt, snap_dig_nxt, snap_apz_nxt);
      bcd_nxt = apagado ? 4'hF : snap_dig_nxt[{idx_nxt, 2'b00} +: 4];
      if (estado_nxt == EST_ATIVO) begin
        dp_nxt = ~snap_pts_nxt[idx_nxt];
        if (!apagado) anodo_nxt[idx_nxt] = 1'b0;
      end
    end
  end

endmodule
